retire_trace_buffer: RTL and testbench
======================================

Name: retire_trace_buffer

Overview:
- Synthesizable retire-event collector between the CPU core's commit signals and the simulation trace and log consumer.
- Each cycle it classifies the retiring instruction as REG, LD, ST, NOP/branch or HALT. It tags the event with an instruction number, counts cycles, and buffers events in a FIFO.
- Events are presented on a valid/ready port, so the consumer can drain them at its own rate.
- It also flags run termination on halt drain or cycle timeout, and flags FIFO overflow.

Parameters:
- DEPTH, 16, FIFO entries; power of 2, at least 2.
- MAX_CYCLES, 100000, cycle count at which the run is declared timed out.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- commit_valid  in  1  an instruction retires this cycle; tied to 1 for the single-cycle core.
- commit_pc  in  16  PC of the retiring instruction.
- reg_we  in  1  register file write.
- rd  in  4  destination register.
- write_data  in  16  register write data.
- mem_re  in  1  data memory read.
- mem_we  in  1  data memory write.
- mem_addr  in  16  data memory address.
- mem_wdata  in  16  store data.
- hlt  in  1  HLT retiring.
- out_valid  out  1  head event available.
- out_ready  in  1  consumer accepts the head event.
- out_kind  out  3  event kind: 0=NOP, 1=REG, 2=LD, 3=ST, 4=HALT.
- out_inum  out  32  instruction number.
- out_pc  out  16  event PC.
- out_reg  out  4  destination register; 0 when the kind has no destination.
- out_value  out  16  register or store value.
- out_addr  out  16  memory address.
- cycle_count  out  32  cycles elapsed in the RUN state.
- inst_count  out  32  instructions retired.
- overflow  out  1  sticky; an event was dropped.
- timeout  out  1  sticky; MAX_CYCLES was reached.
- done  out  1  run finished and the FIFO is drained.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - FIFO empty; all outputs 0.
  - State RUN; counters 0; sticky flags clear.
  - Reset during any state, including a partially drained FIFO, discards all contents immediately.
- States:
  - RUN: capture commits and count cycles.
  - HALTED: ignore commits, counters frozen, FIFO still drains.
  - DONE: terminal until reset.
- Transitions:
  - RUN -> HALTED on an accepted HALT capture.
  - RUN -> DONE when cycle_count reaches MAX_CYCLES; the MAX_CYCLES-th count completes the transition and sets timeout. No further captures; the FIFO still drains.
  - HALTED -> DONE when the FIFO is empty.
- done = (state==DONE) && FIFO empty; registered.
- cycle_count increments every clock edge while in RUN; it wraps at 2^32.
- Classification applies in RUN with commit_valid=1. Priority, highest first:
  - hlt -> HALT.
  - reg_we and mem_re -> LD.
  - reg_we -> REG.
  - mem_we -> ST.
  - otherwise NOP.
- Field fill per kind:
  - REG: reg=rd, value=write_data, addr=0.
  - LD: reg=rd, value=write_data, addr=mem_addr.
  - ST: reg=0, value=mem_wdata, addr=mem_addr.
  - NOP and HALT: reg, value and addr all 0.
  - pc=commit_pc for every kind.
- Instruction numbering:
  - inum = inst_count before increment; the first event is 0.
  - inst_count increments on every capture attempt, including dropped ones, so drops appear as inum gaps.
  - inst_count wraps at 2^32.
- FIFO:
  - Circular, with log2(DEPTH)+1-bit pointers; full and empty come from MSB and index comparison; pointers wrap naturally.
  - Push when full and no pop in the same cycle: event dropped, overflow set (sticky). A dropped HALT still moves the state to HALTED.
  - Push and pop in the same cycle while full: both accepted, occupancy unchanged.
  - No bypass: an event captured at edge N is visible on out_* after edge N, i.e. 1-cycle latency into an empty FIFO.
- Output handshake:
  - out_* reflect the FIFO head; out_valid = !empty.
  - A pop occurs when out_valid && out_ready.
  - While out_valid && !out_ready, all out_* are held stable.
  - out_ready with out_valid=0 has no effect.
  - When out_valid=0, out_* fields are don't-care but driven to 0.
- commit_valid=0 in RUN: no capture, inst_count holds, cycle_count still increments.

Test Plan:
- Reset, then a REG commit (pc 0x0000, rd 3, data 0x1234) with out_ready=1 -> one cycle later out_valid=1, kind 1, inum 0, reg 3, value 0x1234, addr 0.
- LD (rd 5, data 0xBEEF, addr 0x0040), then ST (addr 0x0042, data 0x00AA), then a branch -> kinds 2, 3, 0 with inums 0, 1, 2; the ST entry has value 0x00AA and reg 0.
- out_ready=0 with 20 commits at DEPTH=16 -> 16 entries held, overflow=1, drained inums are 0..15, inst_count=20; entries stay stable while stalled.
- FIFO full with push and pop in the same cycle -> no overflow, occupancy stays 16, the new entry is appended.
- 3 commits then hlt, out_ready=1 -> HALT entry has inum 3; later commits are ignored; done=1 after the last pop; cycle_count frozen.
- MAX_CYCLES=50, no hlt -> timeout=1 at cycle 50; done asserts once the FIFO is empty; asserting rst_n=0 mid-drain clears everything asynchronously.

Source files
------------

// File: rtl/retire_trace_buffer.sv
// Retire-event collector: classifies each committed instruction, tags it with an
// instruction number and queues it in a FIFO drained over a valid/ready port.
module retire_trace_buffer #(
  parameter int DEPTH      = 16,
  parameter int MAX_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        commit_valid,
  input  logic [15:0] commit_pc,
  input  logic        reg_we,
  input  logic [3:0]  rd,
  input  logic [15:0] write_data,
  input  logic        mem_re,
  input  logic        mem_we,
  input  logic [15:0] mem_addr,
  input  logic [15:0] mem_wdata,
  input  logic        hlt,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [2:0]  out_kind,
  output logic [31:0] out_inum,
  output logic [15:0] out_pc,
  output logic [3:0]  out_reg,
  output logic [15:0] out_value,
  output logic [15:0] out_addr,
  output logic [31:0] cycle_count,
  output logic [31:0] inst_count,
  output logic        overflow,
  output logic        timeout,
  output logic        done
);

  localparam int          AW         = $clog2(DEPTH);
  localparam logic [31:0] LAST_COUNT = 32'(MAX_CYCLES - 1);

  typedef enum logic [1:0] {RUN, HALTED, DONE} stateT;

  typedef enum logic [2:0] {
    K_NOP  = 3'd0,
    K_REG  = 3'd1,
    K_LD   = 3'd2,
    K_ST   = 3'd3,
    K_HALT = 3'd4
  } kindT;

  typedef struct packed {
    kindT        kind;
    logic [31:0] inum;
    logic [15:0] pc;
    logic [3:0]  rdest;
    logic [15:0] value;
    logic [15:0] addr;
  } traceEventT;

  stateT      state, stateNext;
  logic       runActive;
  logic       limitHit;
  logic [31:0] cycleCount, instCount;
  logic       overflowFlag, timeoutFlag, doneFlag;

  traceEventT newEvent;
  traceEventT headEvent;
  traceEventT mem [DEPTH];
  logic [AW:0] wrPtr, rdPtr;
  logic       fifoEmpty, fifoFull;
  logic       capture, push, pop, dropped;

  // ---------------------------------------------------------------- classify
  always_comb begin
    // NOTE: every field gets a default first so no path leaves a latch behind.
    newEvent      = '0;
    newEvent.inum = instCount;
    newEvent.pc   = commit_pc;
    if (hlt) begin
      newEvent.kind = K_HALT;
    end else if (reg_we && mem_re) begin
      newEvent.kind  = K_LD;
      newEvent.rdest = rd;
      newEvent.value = write_data;
      newEvent.addr  = mem_addr;
    end else if (reg_we) begin
      newEvent.kind  = K_REG;
      newEvent.rdest = rd;
      newEvent.value = write_data;
    end else if (mem_we) begin
      newEvent.kind  = K_ST;
      newEvent.value = mem_wdata;
      newEvent.addr  = mem_addr;
    end else begin
      newEvent.kind = K_NOP;
    end
  end

  // ---------------------------------------------------------------- FIFO
  assign fifoEmpty = (wrPtr == rdPtr);
  assign fifoFull  = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
  assign capture   = runActive && commit_valid;
  assign pop       = !fifoEmpty && out_ready;
  assign push      = capture && (!fifoFull || pop);
  assign dropped   = capture && fifoFull && !pop;

  // NOTE: storage is not reset; the pointers alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem[wrPtr[AW-1:0]] <= newEvent;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop)  rdPtr <= rdPtr + 1'b1;
    end
  end

  // ---------------------------------------------------------------- run FSM
  assign limitHit = (cycleCount == LAST_COUNT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RUN;
    else        state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      RUN: begin
        // The timeout wins if both end conditions coincide; DONE still drains.
        if (limitHit)                              stateNext = DONE;
        else if (capture && newEvent.kind == K_HALT) stateNext = HALTED;
      end
      HALTED:  if (fifoEmpty) stateNext = DONE;
      DONE:    stateNext = DONE;
      default: stateNext = RUN;
    endcase
  end

  always_comb begin
    runActive = (state == RUN);
  end

  // ---------------------------------------------------------------- counters and flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycleCount   <= '0;
      instCount    <= '0;
      overflowFlag <= 1'b0;
      timeoutFlag  <= 1'b0;
      doneFlag     <= 1'b0;
    end else begin
      if (runActive)             cycleCount   <= cycleCount + 32'd1;
      if (capture)               instCount    <= instCount + 32'd1;
      if (dropped)               overflowFlag <= 1'b1;
      if (runActive && limitHit) timeoutFlag  <= 1'b1;
      doneFlag <= (state == DONE) && fifoEmpty;
    end
  end

  // ---------------------------------------------------------------- outputs
  assign headEvent = fifoEmpty ? traceEventT'('0) : mem[rdPtr[AW-1:0]];

  assign out_valid   = !fifoEmpty;
  assign out_kind    = headEvent.kind;
  assign out_inum    = headEvent.inum;
  assign out_pc      = headEvent.pc;
  assign out_reg     = headEvent.rdest;
  assign out_value   = headEvent.value;
  assign out_addr    = headEvent.addr;
  assign cycle_count = cycleCount;
  assign inst_count  = instCount;
  assign overflow    = overflowFlag;
  assign timeout     = timeoutFlag;
  assign done        = doneFlag;

endmodule

// File: tb/tb_retire_trace_buffer.sv
// Directed bench: one instance with a long run limit, one with MAX_CYCLES=50.
module tb_retire_trace_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        commit_valid;
  logic [15:0] commit_pc;
  logic        reg_we;
  logic [3:0]  rd;
  logic [15:0] write_data;
  logic        mem_re, mem_we;
  logic [15:0] mem_addr, mem_wdata;
  logic        hlt;

  logic        aReady, aValid, aOvf, aTo, aDone;
  logic [2:0]  aKind;
  logic [31:0] aInum, aCycles, aInsts;
  logic [15:0] aPc, aValue, aAddr;
  logic [3:0]  aReg;

  logic        bReady, bValid, bOvf, bTo, bDone;
  logic [2:0]  bKind;
  logic [31:0] bInum, bCycles, bInsts;
  logic [15:0] bPc, bValue, bAddr;
  logic [3:0]  bReg;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  retire_trace_buffer #(.DEPTH(16), .MAX_CYCLES(1000)) dut (
    .clk(clk), .rst_n(rst_n), .commit_valid(commit_valid), .commit_pc(commit_pc),
    .reg_we(reg_we), .rd(rd), .write_data(write_data), .mem_re(mem_re),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .hlt(hlt),
    .out_valid(aValid), .out_ready(aReady), .out_kind(aKind), .out_inum(aInum),
    .out_pc(aPc), .out_reg(aReg), .out_value(aValue), .out_addr(aAddr),
    .cycle_count(aCycles), .inst_count(aInsts), .overflow(aOvf),
    .timeout(aTo), .done(aDone)
  );

  retire_trace_buffer #(.DEPTH(16), .MAX_CYCLES(50)) dutTo (
    .clk(clk), .rst_n(rst_n), .commit_valid(commit_valid), .commit_pc(commit_pc),
    .reg_we(reg_we), .rd(rd), .write_data(write_data), .mem_re(mem_re),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .hlt(hlt),
    .out_valid(bValid), .out_ready(bReady), .out_kind(bKind), .out_inum(bInum),
    .out_pc(bPc), .out_reg(bReg), .out_value(bValue), .out_addr(bAddr),
    .cycle_count(bCycles), .inst_count(bInsts), .overflow(bOvf),
    .timeout(bTo), .done(bDone)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    commit_valid = 1'b0; commit_pc = '0; reg_we = 1'b0; rd = '0; write_data = '0;
    mem_re = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_wdata = '0; hlt = 1'b0;
  endtask

  task automatic commit(input logic [15:0] pc, input logic rwe, input logic [3:0] rdv,
                        input logic [15:0] wd, input logic mre, input logic mwe,
                        input logic [15:0] ma, input logic [15:0] mwd, input logic h);
    commit_valid = 1'b1; commit_pc = pc; reg_we = rwe; rd = rdv; write_data = wd;
    mem_re = mre; mem_we = mwe; mem_addr = ma; mem_wdata = mwd; hlt = h;
  endtask

  // Called just after a rising edge: reset spans no edge and releases mid-cycle.
  task automatic doReset();
    idle();
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
  endtask

  initial begin
    int n;
    idle();
    aReady = 1'b0;
    bReady = 1'b0;
    rst_n  = 1'b0;
    #12;
    check("rst_valid", 32'(aValid), 0);
    check("rst_kind", 32'(aKind), 0);
    check("rst_cycles", aCycles, 0);
    check("rst_insts", aInsts, 0);
    check("rst_flags", {29'd0, aOvf, aTo, aDone}, 0);
    rst_n = 1'b1;
    tick();

    // Single REG commit, 1-cycle latency into an empty FIFO.
    doReset();
    aReady = 1'b1;
    commit(16'h0000, 1'b1, 4'd3, 16'h1234, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    tick();
    idle();
    check("reg_valid", 32'(aValid), 1);
    check("reg_kind", 32'(aKind), 1);
    check("reg_inum", aInum, 0);
    check("reg_rd", 32'(aReg), 3);
    check("reg_value", 32'(aValue), 32'h1234);
    check("reg_addr", 32'(aAddr), 0);
    tick();
    check("reg_popped", 32'(aValid), 0);
    check("reg_zero_kind", 32'(aKind), 0);
    check("reg_insts", aInsts, 1);

    // LD, ST, branch, then REG wins over ST when both write enables are set.
    doReset();
    aReady = 1'b0;
    commit(16'h0010, 1'b1, 4'd5, 16'hBEEF, 1'b1, 1'b0, 16'h0040, 16'h0, 1'b0);
    tick();
    commit(16'h0011, 1'b0, 4'd9, 16'h7777, 1'b0, 1'b1, 16'h0042, 16'h00AA, 1'b0);
    tick();
    commit(16'h0012, 1'b0, 4'd2, 16'h3333, 1'b0, 1'b0, 16'h0050, 16'h0011, 1'b0);
    tick();
    commit(16'h0013, 1'b1, 4'd6, 16'h4444, 1'b0, 1'b1, 16'h0060, 16'h0022, 1'b0);
    tick();
    idle();
    check("ld_kind", 32'(aKind), 2);
    check("ld_inum", aInum, 0);
    check("ld_rd", 32'(aReg), 5);
    check("ld_value", 32'(aValue), 32'hBEEF);
    check("ld_addr", 32'(aAddr), 32'h0040);
    aReady = 1'b1;
    tick();
    check("st_kind", 32'(aKind), 3);
    check("st_inum", aInum, 1);
    check("st_rd", 32'(aReg), 0);
    check("st_value", 32'(aValue), 32'h00AA);
    check("st_addr", 32'(aAddr), 32'h0042);
    tick();
    check("nop_kind", 32'(aKind), 0);
    check("nop_inum", aInum, 2);
    check("nop_pc", 32'(aPc), 32'h0012);
    check("nop_fields", {aValue, aAddr}, 0);
    tick();
    check("prio_kind", 32'(aKind), 1);
    check("prio_addr", 32'(aAddr), 0);
    check("prio_value", 32'(aValue), 32'h4444);
    tick();
    check("lst_empty", 32'(aValid), 0);

    // 20 commits into a stalled 16-entry FIFO.
    doReset();
    aReady = 1'b0;
    for (int i = 0; i < 20; i++) begin
      commit(16'(i), 1'b1, 4'(i), 16'(32'h100 + i), 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
      tick();
    end
    idle();
    check("ovf_flag", 32'(aOvf), 1);
    check("ovf_insts", aInsts, 20);
    tick();
    tick();
    check("stall_inum", aInum, 0);
    check("stall_value", 32'(aValue), 32'h100);
    aReady = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check("ovf_drain_inum", aInum, 32'(i));
      check("ovf_drain_value", 32'(aValue), 32'h100 + 32'(i));
      tick();
    end
    check("ovf_drained", 32'(aValid), 0);

    // Full FIFO with simultaneous push and pop.
    doReset();
    aReady = 1'b0;
    for (int i = 0; i < 16; i++) begin
      commit(16'(i), 1'b1, 4'(i), 16'(32'h200 + i), 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
      tick();
    end
    check("full_no_ovf", 32'(aOvf), 0);
    check("full_insts", aInsts, 16);
    aReady = 1'b1;
    commit(16'd16, 1'b1, 4'd0, 16'h0210, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    tick();
    idle();
    check("pp_no_ovf", 32'(aOvf), 0);
    for (int i = 1; i <= 16; i++) begin
      check("pp_drain_inum", aInum, 32'(i));
      check("pp_drain_value", 32'(aValue), 32'h200 + 32'(i));
      tick();
    end
    check("pp_drained", 32'(aValid), 0);

    // Three commits then HLT, consumer always ready.
    doReset();
    aReady = 1'b1;
    for (int i = 0; i < 3; i++) begin
      commit(16'(32'h20 + i), 1'b1, 4'd1, 16'(32'h10 + i), 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
      tick();
      check("hlt_pre_inum", aInum, 32'(i));
    end
    commit(16'h0023, 1'b1, 4'd7, 16'h5555, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1);
    tick();
    check("hlt_kind", 32'(aKind), 4);
    check("hlt_inum", aInum, 3);
    check("hlt_pc", 32'(aPc), 32'h0023);
    check("hlt_fields", {12'd0, aReg, aValue}, 0);
    commit(16'h0024, 1'b1, 4'd7, 16'h6666, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    tick();
    check("hlt_ignored", 32'(aValid), 0);
    check("hlt_insts", aInsts, 4);
    check("hlt_cycles", aCycles, 4);
    n = 0;
    while (!aDone && n < 5) begin
      tick();
      n++;
    end
    check("hlt_done", 32'(aDone), 1);
    check("hlt_cycles_frozen", aCycles, 4);
    check("hlt_insts_frozen", aInsts, 4);
    idle();

    // Timeout at 50 cycles, then asynchronous reset mid-drain.
    doReset();
    bReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      commit(16'(32'h30 + i), 1'b1, 4'd2, 16'(32'h40 + i), 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
      tick();
    end
    idle();
    for (int i = 0; i < 46; i++) tick();
    check("to_cycles_49", bCycles, 49);
    check("to_not_yet", 32'(bTo), 0);
    tick();
    check("to_cycles_50", bCycles, 50);
    check("to_flag", 32'(bTo), 1);
    tick();
    check("to_frozen", bCycles, 50);
    check("to_not_done", 32'(bDone), 0);
    bReady = 1'b1;
    tick();
    bReady = 1'b0;
    check("to_mid_valid", 32'(bValid), 1);
    check("to_mid_inum", bInum, 1);
    rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(bValid), 0);
    check("arst_flags", {29'd0, bOvf, bTo, bDone}, 0);
    check("arst_counts", bCycles | bInsts, 0);
    check("arst_value", 32'(bValue), 0);
    #2;
    rst_n = 1'b1;
    tick();
    check("arst_discarded", 32'(bValid), 0);

    // Timeout with one queued entry: done follows the final pop.
    doReset();
    bReady = 1'b0;
    commit(16'h0070, 1'b1, 4'd4, 16'h0BAD, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    tick();
    idle();
    for (int i = 0; i < 49; i++) tick();
    check("to2_flag", 32'(bTo), 1);
    check("to2_pending", 32'(bValid), 1);
    check("to2_not_done", 32'(bDone), 0);
    bReady = 1'b1;
    tick();
    check("to2_drained", 32'(bValid), 0);
    n = 0;
    while (!bDone && n < 5) begin
      tick();
      n++;
    end
    check("to2_done", 32'(bDone), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
